// File: rtl/fir_mc_sequencer.sv
// fir_mc_sequencer: multi-channel FIR job sequencer.
// Walks enabled channel descriptors and issues credit-limited engine commands.
module fir_mc_sequencer #(
  parameter int N_CHAN  = 4,
  parameter int ADDR_W  = 32,
  parameter int ITER_W  = 12,
  parameter int LEN_W   = 6,
  parameter int SHIFT_W = 5,
  parameter int MAX_OUT = 2,
  localparam int CH_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [N_CHAN-1:0]           chan_en_i,
  input  logic [N_CHAN*ADDR_W-1:0]    cfg_base_i,
  input  logic [N_CHAN*ITER_W-1:0]    cfg_nb_iter_i,
  input  logic [N_CHAN*ADDR_W-1:0]    cfg_stride_i,
  input  logic [N_CHAN*LEN_W-1:0]     cfg_len_i,
  input  logic [N_CHAN*SHIFT_W-1:0]   cfg_shift_i,
  input  logic [N_CHAN-1:0]           cfg_simplemul_i,
  output logic                        cmd_valid_o,
  input  logic                        cmd_ready_i,
  output logic [ADDR_W-1:0]           cmd_addr_o,
  output logic [LEN_W:0]              cmd_len_o,
  output logic [SHIFT_W-1:0]          cmd_shift_o,
  output logic                        cmd_simplemul_o,
  output logic [CH_W-1:0]             cmd_chan_o,
  output logic                        cmd_last_o,
  input  logic                        eng_done_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [N_CHAN-1:0]           evt_o,
  output logic                        err_o
);

  localparam int CUR_W = CH_W + 1;
  localparam int CRD_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_n;

  logic [N_CHAN-1:0]         sh_en;
  logic [N_CHAN-1:0]         sh_sm;
  logic [N_CHAN*ADDR_W-1:0]  sh_base;
  logic [N_CHAN*ADDR_W-1:0]  sh_stride;
  logic [N_CHAN*ITER_W-1:0]  sh_nb;
  logic [N_CHAN*LEN_W-1:0]   sh_len;
  logic [N_CHAN*SHIFT_W-1:0] sh_shift;

  logic [ADDR_W-1:0]  base_a   [N_CHAN];
  logic [ADDR_W-1:0]  stride_a [N_CHAN];
  logic [ITER_W-1:0]  nb_a     [N_CHAN];
  logic [LEN_W-1:0]   len_a    [N_CHAN];
  logic [SHIFT_W-1:0] shift_a  [N_CHAN];

  logic [CUR_W-1:0]  cur;
  logic [CH_W-1:0]   cur_idx;
  logic [ADDR_W-1:0] acc;
  logic [ITER_W-1:0] it;

  logic [CRD_W-1:0] credits;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CH_W-1:0]  f_chan [MAX_OUT];
  logic             f_last [MAX_OUT];

  logic             in_issue;
  logic             accept;
  logic             is_last;
  logic             fifo_empty;
  logic             done_ok;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             bad_done;
  logic [CH_W-1:0]  head_chan;
  logic             head_last;
  logic             sel_found;
  logic [CUR_W-1:0] sel_idx;

  for (genvar g = 0; g < N_CHAN; g++) begin : g_view
    assign base_a[g]   = sh_base[g*ADDR_W +: ADDR_W];
    assign stride_a[g] = sh_stride[g*ADDR_W +: ADDR_W];
    assign nb_a[g]     = sh_nb[g*ITER_W +: ITER_W];
    assign len_a[g]    = sh_len[g*LEN_W +: LEN_W];
    assign shift_a[g]  = sh_shift[g*SHIFT_W +: SHIFT_W];
  end

  assign cur_idx    = cur[CH_W-1:0];
  assign in_issue   = (state == S_ISSUE);
  assign accept     = cmd_valid_o && cmd_ready_i;
  assign is_last    = (it == nb_a[cur_idx]);
  assign fifo_empty = (credits == '0);
  // A completion with nothing queued is only legal for the command
  // being accepted in the same cycle; it then bypasses the FIFO.
  assign done_ok    = eng_done_i && (!fifo_empty || accept);
  assign bypass     = fifo_empty && accept && eng_done_i;
  assign push       = accept && !bypass;
  assign pop        = eng_done_i && !fifo_empty;
  assign bad_done   = eng_done_i && fifo_empty && !accept;
  assign head_chan  = fifo_empty ? cur_idx : f_chan[rd_ptr];
  assign head_last  = fifo_empty ? is_last : f_last[rd_ptr];

  // Lowest enabled channel at or above the current index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (sh_en[i] && (CUR_W'(i) >= cur)) begin
        sel_found = 1'b1;
        sel_idx   = CUR_W'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else if (clear_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (start_i) state_n = S_SELECT;
      S_SELECT: state_n = sel_found ? S_ISSUE : S_DRAIN;
      S_ISSUE:  if (accept && is_last) state_n = S_SELECT;
      S_DRAIN:  if (fifo_empty) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // FSM outputs; command fields are zero outside ISSUE.
  always_comb begin
    busy_o          = (state != S_IDLE);
    done_o          = (state == S_DONE);
    cmd_valid_o     = in_issue && (credits < CRD_MAX);
    cmd_addr_o      = '0;
    cmd_len_o       = '0;
    cmd_shift_o     = '0;
    cmd_simplemul_o = 1'b0;
    cmd_chan_o      = '0;
    cmd_last_o      = 1'b0;
    if (in_issue) begin
      cmd_addr_o      = acc;
      cmd_len_o       = (LEN_W+1)'(len_a[cur_idx]) + (LEN_W+1)'(1);
      cmd_shift_o     = shift_a[cur_idx];
      cmd_simplemul_o = sh_sm[cur_idx];
      cmd_chan_o      = cur_idx;
      cmd_last_o      = is_last;
    end
    evt_o = '0;
    if (done_ok && head_last) evt_o[head_chan] = 1'b1;
  end

  // Descriptor shadow and address/iteration counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_en     <= '0;
      sh_sm     <= '0;
      sh_base   <= '0;
      sh_stride <= '0;
      sh_nb     <= '0;
      sh_len    <= '0;
      sh_shift  <= '0;
      cur       <= '0;
      acc       <= '0;
      it        <= '0;
    end else if (clear_i) begin
      sh_en     <= '0;
      sh_sm     <= '0;
      sh_base   <= '0;
      sh_stride <= '0;
      sh_nb     <= '0;
      sh_len    <= '0;
      sh_shift  <= '0;
      cur       <= '0;
      acc       <= '0;
      it        <= '0;
    end else begin
      if ((state == S_IDLE) && start_i) begin
        sh_en     <= chan_en_i;
        sh_sm     <= cfg_simplemul_i;
        sh_base   <= cfg_base_i;
        sh_stride <= cfg_stride_i;
        sh_nb     <= cfg_nb_iter_i;
        sh_len    <= cfg_len_i;
        sh_shift  <= cfg_shift_i;
        cur       <= '0;
      end
      if ((state == S_SELECT) && sel_found) begin
        cur <= sel_idx;
        acc <= base_a[sel_idx[CH_W-1:0]];
        it  <= '0;
      end
      if (accept) begin
        acc <= acc + stride_a[cur_idx];
        it  <= it + ITER_W'(1);
        if (is_last) cur <= cur + CUR_W'(1);
      end
    end
  end

  // Credit counter, FIFO pointers and sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_o   <= 1'b0;
    end else if (clear_i) begin
      credits <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_o   <= 1'b0;
    end else begin
      unique case ({accept, done_ok})
        2'b10:   credits <= credits + CRD_W'(1);
        2'b01:   credits <= credits - CRD_W'(1);
        default: credits <= credits;
      endcase
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      err_o <= (err_o && !start_i) || bad_done;
    end
  end

  // Tracking FIFO storage of {chan, last} per accepted command.
  always_ff @(posedge clk_i) begin
    if (push) begin
      f_chan[wr_ptr] <= cur_idx;
      f_last[wr_ptr] <= is_last;
    end
  end

endmodule

// File: tb/tb_fir_mc_sequencer.sv
// tb_fir_mc_sequencer: randomized bench for the multi-channel FIR sequencer.
// Expected command streams are derived from the descriptors with plain arithmetic.
module tb_fir_mc_sequencer;

  localparam int N_CHAN  = 4;
  localparam int ADDR_W  = 32;
  localparam int ITER_W  = 12;
  localparam int LEN_W   = 6;
  localparam int SHIFT_W = 5;
  localparam int MAX_OUT = 2;
  localparam int CH_W    = 2;

  logic clk = 1'b0;
  logic rst_i, clear_i, start_i;
  logic [N_CHAN-1:0]         chan_en_i;
  logic [N_CHAN*ADDR_W-1:0]  cfg_base_i;
  logic [N_CHAN*ITER_W-1:0]  cfg_nb_iter_i;
  logic [N_CHAN*ADDR_W-1:0]  cfg_stride_i;
  logic [N_CHAN*LEN_W-1:0]   cfg_len_i;
  logic [N_CHAN*SHIFT_W-1:0] cfg_shift_i;
  logic [N_CHAN-1:0]         cfg_simplemul_i;
  logic                      cmd_valid_o, cmd_ready_i;
  logic [ADDR_W-1:0]         cmd_addr_o;
  logic [LEN_W:0]            cmd_len_o;
  logic [SHIFT_W-1:0]        cmd_shift_o;
  logic                      cmd_simplemul_o;
  logic [CH_W-1:0]           cmd_chan_o;
  logic                      cmd_last_o;
  logic                      eng_done_i;
  logic                      busy_o, done_o, err_o;
  logic [N_CHAN-1:0]         evt_o;

  bit   tie;
  logic ready_drv, done_drv;
  assign cmd_ready_i = tie ? cmd_valid_o : ready_drv;
  assign eng_done_i  = tie ? cmd_valid_o : done_drv;

  always #5 clk = ~clk;

  fir_mc_sequencer #(
    .N_CHAN(N_CHAN), .ADDR_W(ADDR_W), .ITER_W(ITER_W), .LEN_W(LEN_W),
    .SHIFT_W(SHIFT_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .chan_en_i(chan_en_i), .cfg_base_i(cfg_base_i),
    .cfg_nb_iter_i(cfg_nb_iter_i), .cfg_stride_i(cfg_stride_i),
    .cfg_len_i(cfg_len_i), .cfg_shift_i(cfg_shift_i),
    .cfg_simplemul_i(cfg_simplemul_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o),
    .cmd_shift_o(cmd_shift_o), .cmd_simplemul_o(cmd_simplemul_o),
    .cmd_chan_o(cmd_chan_o), .cmd_last_o(cmd_last_o),
    .eng_done_i(eng_done_i), .busy_o(busy_o), .done_o(done_o),
    .evt_o(evt_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] c_base   [N_CHAN];
  logic [ADDR_W-1:0] c_stride [N_CHAN];
  int                c_nb     [N_CHAN];
  int                c_len    [N_CHAN];
  int                c_shift  [N_CHAN];
  bit                c_sm     [N_CHAN];
  logic [N_CHAN-1:0] c_mask;

  logic [ADDR_W-1:0] ex_addr[$];
  int                ex_chan[$];
  bit                ex_last[$];
  logic [N_CHAN-1:0] ex_evt[$];

  logic [ADDR_W-1:0] ob_addr[$];
  int                ob_chan[$];
  bit                ob_last[$];
  int                ob_len[$];
  int                ob_shift[$];
  bit                ob_sm[$];
  logic [N_CHAN-1:0] ob_evt[$];
  int done_cnt, done_cyc, over_cnt, stray_cnt;
  bit timed_out;

  task automatic apply_cfg();
    chan_en_i = c_mask;
    for (int i = 0; i < N_CHAN; i++) begin
      cfg_base_i[i*ADDR_W +: ADDR_W]    = c_base[i];
      cfg_stride_i[i*ADDR_W +: ADDR_W]  = c_stride[i];
      cfg_nb_iter_i[i*ITER_W +: ITER_W] = ITER_W'(c_nb[i]);
      cfg_len_i[i*LEN_W +: LEN_W]       = LEN_W'(c_len[i]);
      cfg_shift_i[i*SHIFT_W +: SHIFT_W] = SHIFT_W'(c_shift[i]);
      cfg_simplemul_i[i]                = c_sm[i];
    end
  endtask

  task automatic zero_cfg();
    c_mask = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      c_base[i] = '0; c_stride[i] = '0; c_nb[i] = 0;
      c_len[i] = 0; c_shift[i] = 0; c_sm[i] = 0;
    end
  endtask

  // Reference: channels in index order, address = base + k*stride.
  task automatic build_expected();
    ex_addr.delete(); ex_chan.delete(); ex_last.delete(); ex_evt.delete();
    for (int ch = 0; ch < N_CHAN; ch++) begin
      if (c_mask[ch]) begin
        for (int k = 0; k <= c_nb[ch]; k++) begin
          ex_addr.push_back(c_base[ch] + ADDR_W'(k) * c_stride[ch]);
          ex_chan.push_back(ch);
          ex_last.push_back(k == c_nb[ch]);
        end
        ex_evt.push_back(N_CHAN'(1) << ch);
      end
    end
  endtask

  // Drives one job and records what the DUT issued.
  task automatic run_job(input int ready_pct, input int done_pct,
                         input bit tied, input int restart_at,
                         input int max_cyc);
    int out;
    bit a;
    ob_addr.delete(); ob_chan.delete(); ob_last.delete();
    ob_len.delete(); ob_shift.delete(); ob_sm.delete(); ob_evt.delete();
    done_cnt = 0; done_cyc = -1; over_cnt = 0; stray_cnt = 0;
    timed_out = 1; out = 0; tie = tied;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      start_i = (n == 0) || (n == restart_at);
      if (n == restart_at) begin
        cfg_base_i = ~cfg_base_i;
        chan_en_i  = ~chan_en_i;
      end
      ready_drv = ($urandom_range(99) < ready_pct);
      done_drv  = (out > 0) && ($urandom_range(99) < done_pct);
      #1;
      if (cmd_valid_o && out >= MAX_OUT) over_cnt++;
      a = cmd_valid_o && cmd_ready_i;
      if (a) begin
        ob_addr.push_back(cmd_addr_o);
        ob_chan.push_back(int'(cmd_chan_o));
        ob_last.push_back(cmd_last_o);
        ob_len.push_back(int'(cmd_len_o));
        ob_shift.push_back(int'(cmd_shift_o));
        ob_sm.push_back(cmd_simplemul_o);
      end
      if (evt_o != '0) ob_evt.push_back(evt_o);
      if (evt_o != '0 && !eng_done_i) stray_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (!tied) out = out + int'(a) - int'(done_drv);
      if (done_cyc >= 0 && n >= done_cyc + 4) begin
        timed_out = 0;
        break;
      end
    end
    start_i = 0; ready_drv = 0; done_drv = 0; tie = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; clear_i = 0; start_i = 0; tie = 0;
    ready_drv = 0; done_drv = 0;
    zero_cfg(); apply_cfg();
    repeat (2) @(negedge clk);
    total++;
    if ({cmd_valid_o, cmd_addr_o, cmd_len_o, cmd_shift_o, cmd_simplemul_o,
         cmd_chan_o, cmd_last_o, busy_o, done_o, evt_o, err_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b addr=%h len=%h busy=%b err=%b evt=%b want all 0",
               cmd_valid_o, cmd_addr_o, cmd_len_o, busy_o, err_o, evt_o);
    end
    rst_i = 0;
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_two_chan();
    zero_cfg();
    c_mask = 4'b0101;
    c_base[0] = 32'h1000; c_stride[0] = 32'h40; c_nb[0] = 2; c_len[0] = 7;
    c_base[2] = 32'h2000; c_stride[2] = 32'h4;  c_nb[2] = 0; c_len[2] = 3;
    apply_cfg(); build_expected();
    run_job(100, 0, 1, -1, 100);
    total++;
    if (timed_out) begin bad++; $display("FAIL two_chan_timeout: no done_o within budget"); end
    total++;
    if (ob_addr.size() != ex_addr.size()) begin
      bad++; $display("FAIL two_chan_count: got %0d want %0d", ob_addr.size(), ex_addr.size());
    end else begin
      for (int k = 0; k < ex_addr.size(); k++) begin
        total++;
        if (ob_addr[k] !== ex_addr[k] || ob_chan[k] != ex_chan[k] || ob_last[k] != ex_last[k]) begin
          bad++;
          $display("FAIL two_chan_cmd[%0d]: got %h/%0d/%0d want %h/%0d/%0d", k,
                   ob_addr[k], ob_chan[k], ob_last[k], ex_addr[k], ex_chan[k], ex_last[k]);
        end
      end
    end
    total++;
    if (ob_evt.size() != 2 || ob_evt[0] !== 4'b0001 || ob_evt[1] !== 4'b0100) begin
      bad++; $display("FAIL two_chan_evt: got %0d events want 0001,0100", ob_evt.size());
    end
    total++;
    if (done_cnt != 1 || err_o !== 1'b0) begin
      bad++; $display("FAIL two_chan_done: done_cnt=%0d err=%b want 1/0", done_cnt, err_o);
    end
  endtask

  task automatic test_credits();
    int n_acc;
    zero_cfg();
    c_mask = 4'b0001; c_base[0] = 32'h3000; c_stride[0] = 32'h8; c_nb[0] = 5;
    apply_cfg();
    tie = 0; ready_drv = 1; done_drv = 0;
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0; #1;
    total++;
    if (cmd_valid_o !== 1'b0) begin
      bad++; $display("FAIL credits_select_bubble: valid=%b want 0", cmd_valid_o);
    end
    @(negedge clk); #1;
    total++;
    if (cmd_valid_o !== 1'b1 || cmd_addr_o !== 32'h3000) begin
      bad++; $display("FAIL credits_first_valid: valid=%b addr=%h want 1/3000", cmd_valid_o, cmd_addr_o);
    end
    n_acc = int'(cmd_valid_o && cmd_ready_i);
    repeat (5) begin
      @(negedge clk); #1;
      if (cmd_valid_o && cmd_ready_i) n_acc++;
    end
    total++;
    if (n_acc != MAX_OUT || cmd_valid_o !== 1'b0) begin
      bad++; $display("FAIL credits_limit: accepts=%0d valid=%b want %0d/0", n_acc, cmd_valid_o, MAX_OUT);
    end
    @(negedge clk); done_drv = 1; #1;
    total++;
    if (cmd_valid_o !== 1'b0 || evt_o !== '0) begin
      bad++; $display("FAIL credits_done_cycle: valid=%b evt=%b want 0/0", cmd_valid_o, evt_o);
    end
    @(negedge clk); done_drv = 0; #1;
    total++;
    if (cmd_valid_o !== 1'b1 || cmd_addr_o !== 32'h3010) begin
      bad++; $display("FAIL credits_third: valid=%b addr=%h want 1/3010", cmd_valid_o, cmd_addr_o);
    end
    @(negedge clk); ready_drv = 0; clear_i = 1;
    @(negedge clk); clear_i = 0;
  endtask

  task automatic test_wrap();
    zero_cfg();
    c_mask = 4'b0001; c_base[0] = 32'hFFFF_FFF0; c_stride[0] = 32'h10; c_nb[0] = 1;
    apply_cfg(); build_expected();
    run_job(70, 60, 0, -1, 200);
    total++;
    if (timed_out || ob_addr.size() != 2) begin
      bad++; $display("FAIL wrap_count: timeout=%0d cmds=%0d want 0/2", timed_out, ob_addr.size());
    end else begin
      total++;
      if (ob_addr[0] !== 32'hFFFF_FFF0 || ob_addr[1] !== 32'h0000_0000) begin
        bad++; $display("FAIL wrap_addr: got %h,%h want fffffff0,00000000", ob_addr[0], ob_addr[1]);
      end
    end
  endtask

  task automatic test_restart_busy();
    zero_cfg();
    c_mask = 4'b0011;
    c_base[0] = 32'h4000; c_stride[0] = 32'h20; c_nb[0] = 3;
    c_base[1] = 32'h5000; c_stride[1] = 32'h100; c_nb[1] = 2;
    apply_cfg(); build_expected();
    run_job(80, 50, 0, 4, 300);
    total++;
    if (timed_out || done_cnt != 1) begin
      bad++; $display("FAIL restart_done: timeout=%0d done_cnt=%0d want 0/1", timed_out, done_cnt);
    end
    total++;
    if (ob_addr != ex_addr) begin
      bad++; $display("FAIL restart_addrs: got %0d cmds want %0d, stream differs", ob_addr.size(), ex_addr.size());
    end
  endtask

  task automatic test_empty_mask();
    zero_cfg(); apply_cfg();
    run_job(100, 0, 0, -1, 30);
    total++;
    if (timed_out || done_cyc != 3) begin
      bad++; $display("FAIL empty_done_latency: timeout=%0d done_cyc=%0d want 0/3", timed_out, done_cyc);
    end
    total++;
    if (ob_addr.size() != 0 || ob_evt.size() != 0 || done_cnt != 1) begin
      bad++; $display("FAIL empty_nothing: cmds=%0d evts=%0d done=%0d want 0/0/1",
                      ob_addr.size(), ob_evt.size(), done_cnt);
    end
  endtask

  task automatic test_clear();
    zero_cfg();
    c_mask = 4'b0001; c_base[0] = 32'h6000; c_stride[0] = 32'h4; c_nb[0] = 7;
    apply_cfg();
    tie = 0; ready_drv = 1; done_drv = 0;
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0;
    repeat (3) @(negedge clk);
    clear_i = 1;
    @(negedge clk); clear_i = 0; done_drv = 1; #1;
    total++;
    if (evt_o !== '0 || cmd_valid_o !== 1'b0) begin
      bad++; $display("FAIL clear_late_done: evt=%b valid=%b want 0/0", evt_o, cmd_valid_o);
    end
    @(negedge clk); done_drv = 0; #1;
    total++;
    if ({cmd_valid_o, cmd_addr_o, cmd_len_o, cmd_shift_o, cmd_simplemul_o,
         cmd_chan_o, cmd_last_o, busy_o, done_o, evt_o} !== '0 || err_o !== 1'b1) begin
      bad++; $display("FAIL clear_state: valid=%b busy=%b addr=%h err=%b want 0/0/0/1",
                      cmd_valid_o, busy_o, cmd_addr_o, err_o);
    end
    repeat (3) @(negedge clk);
    total++;
    if (err_o !== 1'b1) begin
      bad++; $display("FAIL clear_err_sticky: err=%b want 1", err_o);
    end
    zero_cfg(); apply_cfg();
    start_i = 1;
    @(negedge clk); start_i = 0;
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL clear_err_start: err=%b want 0", err_o);
    end
    repeat (5) @(negedge clk);
    ready_drv = 0;
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      zero_cfg();
      c_mask = N_CHAN'($urandom_range(15));
      for (int i = 0; i < N_CHAN; i++) begin
        c_base[i]   = $urandom;
        c_stride[i] = $urandom_range(255) << 2;
        c_nb[i]     = $urandom_range(5);
        c_len[i]    = $urandom_range(63);
        c_shift[i]  = $urandom_range(31);
        c_sm[i]     = 1'($urandom_range(1));
      end
      apply_cfg(); build_expected();
      run_job($urandom_range(100, 40), $urandom_range(90, 30), 0, -1, 2000);
      total++;
      if (timed_out || done_cnt != 1 || over_cnt != 0 || stray_cnt != 0 || err_o !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d_job: timeout=%0d done=%0d over=%0d stray=%0d err=%b want 0/1/0/0/0",
                 j, timed_out, done_cnt, over_cnt, stray_cnt, err_o);
      end
      total++;
      if (ob_addr.size() != ex_addr.size()) begin
        bad++; $display("FAIL rand%0d_count: got %0d want %0d", j, ob_addr.size(), ex_addr.size());
      end else begin
        for (int k = 0; k < ex_addr.size(); k++) begin
          total++;
          if (ob_addr[k] !== ex_addr[k] || ob_chan[k] != ex_chan[k] || ob_last[k] != ex_last[k] ||
              ob_len[k] != c_len[ex_chan[k]] + 1 || ob_shift[k] != c_shift[ex_chan[k]] ||
              ob_sm[k] != c_sm[ex_chan[k]]) begin
            bad++;
            $display("FAIL rand%0d_cmd[%0d]: got %h/%0d/%0d len%0d want %h/%0d/%0d len%0d", j, k,
                     ob_addr[k], ob_chan[k], ob_last[k], ob_len[k],
                     ex_addr[k], ex_chan[k], ex_last[k], c_len[ex_chan[k]] + 1);
          end
        end
      end
      total++;
      if (ob_evt != ex_evt) begin
        bad++; $display("FAIL rand%0d_evt: got %0d events want %0d, order or value differs",
                        j, ob_evt.size(), ex_evt.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_chan();
    test_credits();
    test_wrap();
    test_restart_busy();
    test_empty_mask();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_mc_sequencer.md
# fir_mc_sequencer

Multi-channel job sequencer for the FIR accelerator and successor to the single-channel FIR controller. It is programmed with N_CHAN independent channel descriptors: base address, iteration count, tap length, shift and simple-mul mode. On start it walks the enabled channels in index order and issues one engine command per iteration over a valid/ready handshake, with a bounded number of commands in flight. It sits between the register file outputs and the streamer/engine. It replaces the microcode loop with counter-based address generation and adds per-channel completion events.

## Interface
- N_CHAN, 4: number of channel descriptors (1..16).
- ADDR_W, 32: address width.
- ITER_W, 12: iteration-count field width.
- LEN_W, 6: tap-length field width.
- SHIFT_W, 5: shift field width.
- MAX_OUT, 2: maximum commands accepted but not yet completed (1..8).
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- start_i  in  1  job start pulse.
- chan_en_i  in  N_CHAN  channel enable mask.
- cfg_base_i  in  N_CHAN×ADDR_W  per-channel base address.
- cfg_nb_iter_i  in  N_CHAN×ITER_W  iterations minus one.
- cfg_stride_i  in  N_CHAN×ADDR_W  byte stride between iterations.
- cfg_len_i  in  N_CHAN×LEN_W  taps minus one.
- cfg_shift_i  in  N_CHAN×SHIFT_W  output shift.
- cfg_simplemul_i  in  N_CHAN  simple-mul mode.
- cmd_valid_o  out  1  command valid.
- cmd_ready_i  in  1  command accepted by the streamer/engine.
- cmd_addr_o  out  ADDR_W  iteration address.
- cmd_len_o  out  LEN_W+1  taps, equal to cfg_len+1.
- cmd_shift_o  out  SHIFT_W  shift.
- cmd_simplemul_o  out  1  mode.
- cmd_chan_o  out  $clog2(N_CHAN) (minimum 1)  channel index.
- cmd_last_o  out  1  last iteration of the channel.
- eng_done_i  in  1  one command completed; completions return in issue order.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle job-complete pulse.
- evt_o  out  N_CHAN  one-cycle per-channel completion pulse.
- err_o  out  1  sticky protocol error.

## Operation
- Reset value of every output is 0. Reset also sets the FSM to IDLE, the credit count to 0 and the tracking FIFO to empty. clear_i has the same effect on the next edge.
- Shadowing: start_i in IDLE latches all cfg_* inputs and chan_en_i. Later changes to these inputs do not affect the running job. start_i outside IDLE is ignored.
- FSM states: IDLE, SELECT, ISSUE, DRAIN, DONE.
  - IDLE -> SELECT on start_i.
  - SELECT: a priority encoder picks the lowest enabled channel at index ≥ cur. It loads cur, sets acc = base and it = 0, then goes to ISSUE. If no such channel remains, it goes to DRAIN.
  - ISSUE: cmd_valid_o is high while credits < MAX_OUT. On accept: acc += stride (modulo 2^ADDR_W) and it++. If it was nb_iter (cmd_last_o = 1), go to SELECT with cur+1.
  - DRAIN: wait until credits == 0, then go to DONE.
  - DONE: done_o = 1 for one cycle, then IDLE.
- busy_o is 1 in every state except IDLE.
- Credits: +1 on accept, −1 on eng_done_i. Accept and done in the same cycle leave credits unchanged.
- Tracking FIFO (depth MAX_OUT): holds {chan, last} for each accepted command. It is pushed on accept and popped on eng_done_i. A pop whose last = 1 pulses evt_o[chan] in the same cycle as eng_done_i.
- eng_done_i with credits == 0 is ignored except that it sets err_o. err_o clears on start_i or clear_i.
- Command fields are registered and stable while cmd_valid_o is high and cmd_ready_i is low. cmd_valid_o is never withdrawn before acceptance.
- Empty mask: start_i with chan_en_i == 0 takes IDLE -> SELECT -> DRAIN -> DONE. done_o pulses and no command or evt_o is issued.

## Timing
- start_i sampled at edge T. SELECT is active in cycle T+1. The first cmd_valid_o is in cycle T+2.
- Within a channel, accepts can occur back to back (one per cycle) while credits allow.
- Channel switch costs one bubble cycle (SELECT).
- done_o is asserted 2 cycles after the eng_done_i that brings credits to 0: DRAIN sees credits 0 in the next cycle, then DONE.
- evt_o has zero latency relative to the eng_done_i that carries last = 1.
- Reset or clear mid-job aborts the job. Late eng_done_i pulses then see credits == 0 and set err_o.

## Test plan
- N_CHAN=4, mask 4'b0101. ch0: base 0x1000, stride 0x40, nb_iter 2. ch2: base 0x2000, stride 4, nb_iter 0. cmd_ready_i and eng_done_i both tied to cmd_valid_o -> addrs 0x1000, 0x1040, 0x1080 (chan 0, last on the third), then 0x2000 (chan 2, last). evt_o[0] and evt_o[2] pulse, and done_o pulses once.
- MAX_OUT=2, cmd_ready_i = 1, eng_done_i held low -> exactly 2 accepts, then cmd_valid_o low. One eng_done_i pulse -> a third accept in the next cycle.
- Base 0xFFFF_FFF0, stride 0x10, nb_iter 1 -> addrs 0xFFFF_FFF0, then 0x0000_0000 (wrap).
- Change cfg_base_i and assert start_i again while busy -> issued addresses unchanged. No second job runs and done_o pulses once.
- Mask 0 -> done_o 3 cycles after start_i, and cmd_valid_o never rises.
- clear_i during ISSUE, followed by an eng_done_i pulse -> all outputs 0 and the FSM in IDLE. err_o = 1 until the next start_i.
